// File: rtl/multicycle_fsm.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/execute/writeback,
// stalls on memory ready, traps on illegal opcodes and counts retired instructions.
module multicycle_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_operand,
  input  logic             i_zeroFlag,
  input  logic             i_memReady,
  output logic             o_irWriteEn,
  output logic             o_pcWriteEn,
  output logic             o_regWriteEn,
  output logic             o_memWriteEn,
  output logic             o_adrSel,
  output logic [1:0]       o_aluSrcASel,
  output logic [1:0]       o_aluSrcBSel,
  output logic [1:0]       o_aluOp,
  output logic [1:0]       o_resultSel,
  output logic             o_trap,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_retiredCount
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           state_q;
  state_t           state_next;
  logic             trap_q;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic ir_we;
  logic pc_we;
  logic reg_we;
  logic mem_we;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      trap_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_next;
      if (state_next == S_TRAP) begin
        trap_q <= 1'b1;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next   = state_q;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    reg_we       = 1'b0;
    mem_we       = 1'b0;
    retire       = 1'b0;
    o_adrSel     = 1'b0;
    o_aluSrcASel = 2'b00;
    o_aluSrcBSel = 2'b00;
    o_aluOp      = 2'b00;
    o_resultSel  = 2'b00;
    case (state_q)
      S_FETCH: begin
        o_aluSrcBSel = 2'b10;
        o_resultSel  = 2'b10;
        if (i_memReady) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        // ALU precomputes oldPC + imm here as the branch/JAL target
        o_aluSrcASel = 2'b01;
        o_aluSrcBSel = 2'b01;
        case (i_operand)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_B:         state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        o_aluSrcASel = 2'b10;
        o_aluSrcBSel = 2'b01;
        state_next   = (i_operand == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adrSel = 1'b1;
        if (i_memReady) begin
          state_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        o_resultSel = 2'b01;
        reg_we      = 1'b1;
        retire      = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adrSel = 1'b1;
        mem_we   = 1'b1;
        if (i_memReady) begin
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECR: begin
        o_aluSrcASel = 2'b10;
        o_aluOp      = 2'b10;
        state_next   = S_ALUWB;
      end
      S_EXECI: begin
        o_aluSrcASel = 2'b10;
        o_aluSrcBSel = 2'b01;
        o_aluOp      = 2'b10;
        state_next   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we     = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value oldPC + 4
        o_aluSrcASel = 2'b01;
        o_aluSrcBSel = 2'b10;
        pc_we        = 1'b1;
        state_next   = S_ALUWB;
      end
      S_BEQ: begin
        o_aluSrcASel = 2'b10;
        o_aluOp      = 2'b01;
        pc_we        = i_zeroFlag;
        retire       = 1'b1;
        state_next   = S_FETCH;
      end
      S_TRAP: begin
        state_next = S_TRAP;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Reset overrides everything combinationally so no write escapes on the reset edge
  assign o_irWriteEn    = ir_we  & ~i_rst;
  assign o_pcWriteEn    = pc_we  & ~i_rst;
  assign o_regWriteEn   = reg_we & ~i_rst;
  assign o_memWriteEn   = mem_we & ~i_rst;
  assign o_trap         = trap_q;
  assign o_state        = state_q;
  assign o_retiredCount = count_q;

  trap_sticky: assert property (@(posedge i_clk) disable iff (i_rst) trap_q |=> trap_q);
  memwrite_only_in_state: assert property (@(posedge i_clk)
    o_memWriteEn |-> (state_q == S_MEMWRITE));

endmodule
